// File: rtl/seven_seg_capture_if.sv
// Scanned 7-segment display bus as seen at the capture input.
// The display side (or a bench) drives it through the master modport.
// The capture block observes it through the slave modport.
interface seven_seg_capture_if;
   logic [6:0] segments_in;   // gfedcba, active-low
   logic [3:0] anodes_in;     // digit enables, active-low, bit0 = rightmost

   modport master (
      output segments_in,
      output anodes_in
   );

   modport slave (
      input segments_in,
      input anodes_in
   );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed 4-digit 7-segment display path.
// Samples the scanned bus and decodes each settled digit back to a code.
// Reassembles d0..d3 scan frames and reports:
//   - the displayed number,
//   - whether it is one of the four legal duty-cycle displays.
module seven_seg_capture #(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
   input  logic                  clk,
   input  logic                  reset_n,
   seven_seg_capture_if.slave    bus,
   output logic [15:0]           digits_out,
   output logic                  frame_valid,
   output logic [13:0]           value_bin,
   output logic [1:0]            duty_sel_out,
   output logic                  value_ok,
   output logic                  seg_error,
   output logic                  timeout
);

   localparam int ST_W = $clog2(SETTLE_CYCLES) + 1;
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_WAIT_SYNC,
      S_COLLECT,
      S_PUBLISH
   } state_t;

   // Active-low gfedcba pattern -> digit code (15 blank, 14 unrecognised)
   function automatic logic [3:0] f_decode(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'b1000000: code = 4'd0;
         7'b1111001: code = 4'd1;
         7'b0100100: code = 4'd2;
         7'b0110000: code = 4'd3;
         7'b0011001: code = 4'd4;
         7'b0010010: code = 4'd5;
         7'b0000010: code = 4'd6;
         7'b1111000: code = 4'd7;
         7'b0000000: code = 4'd8;
         7'b0010000: code = 4'd9;
         7'b1111111: code = 4'hF;
         default:    code = 4'hE;
      endcase
      return code;
   endfunction

   logic [6:0]      r_seg_s1, r_seg_s2;
   logic [3:0]      r_an_s1, r_an_s2;
   logic [10:0]     r_prev;
   logic [ST_W-1:0] r_stab_cnt;
   logic            r_sampled;
   state_t          r_state, w_state_next;
   logic [3:0]      r_mask, w_mask_next;
   logic [3:0]      r_shadow [4];
   logic [TO_W-1:0] r_to_cnt;
   logic [15:0]     r_digits;
   logic            r_frame_valid;
   logic [13:0]     r_value_bin;
   logic [1:0]      r_duty;
   logic            r_value_ok;
   logic            r_seg_error;
   logic            r_timeout;

   logic            w_an_valid;
   logic [1:0]      w_k;
   logic            w_stable;
   logic            w_sample;
   logic [3:0]      w_code;
   logic            w_shadow_we;
   logic            w_publish;
   logic            w_completing;
   logic            w_abort;
   logic            w_to_hit;
   logic [15:0]     w_shadow_flat;
   logic [3:0]      w_dval [4];
   logic [13:0]     w_value;
   logic            w_legal;
   logic [1:0]      w_legal_sel;

   // Two-flop synchronisers on both buses; idle (all-ones) after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seg_s1 <= '1;
         r_seg_s2 <= '1;
         r_an_s1  <= '1;
         r_an_s2  <= '1;
      end else begin
         r_seg_s1 <= bus.segments_in;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= bus.anodes_in;
         r_an_s2  <= r_an_s1;
      end
   end

   // Exactly one active anode selects a digit; anything else means no digit
   always_comb begin
      w_an_valid = 1'b1;
      w_k        = 2'd0;
      case (r_an_s2)
         4'b1110: w_k = 2'd0;
         4'b1101: w_k = 2'd1;
         4'b1011: w_k = 2'd2;
         4'b0111: w_k = 2'd3;
         default: w_an_valid = 1'b0;
      endcase
   end

   assign w_stable = w_an_valid && ({r_an_s2, r_seg_s2} == r_prev);
   // Fires on the SETTLE_CYCLES-th identical cycle, once per dwell
   assign w_sample = w_stable && !r_sampled && (r_stab_cnt == ST_MAX - 1'b1);
   assign w_code   = f_decode(r_seg_s2);

   // Settling counter: a segment glitch inside a dwell restarts it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev     <= '1;
         r_stab_cnt <= '0;
         r_sampled  <= 1'b0;
      end else begin
         r_prev <= {r_an_s2, r_seg_s2};
         if (!w_stable) begin
            r_stab_cnt <= '0;
            r_sampled  <= 1'b0;
         end else begin
            if (r_stab_cnt != ST_MAX)
               r_stab_cnt <= r_stab_cnt + 1'b1;
            if (w_sample)
               r_sampled <= 1'b1;
         end
      end
   end

   assign w_to_hit = (r_to_cnt == TO_MAX - 1'b1);

   // Frame FSM next state: collect d0 first, then any order until all four seen
   always_comb begin
      w_state_next = r_state;
      w_mask_next  = r_mask;
      w_shadow_we  = 1'b0;
      w_publish    = 1'b0;
      w_completing = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         S_WAIT_SYNC: begin
            if (w_sample && (w_k == 2'd0)) begin
               w_shadow_we  = 1'b1;
               w_mask_next  = 4'b0001;
               w_state_next = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (w_sample) begin
               w_shadow_we = 1'b1;
               w_mask_next = r_mask | ~r_an_s2;
               if (w_mask_next == 4'b1111) begin
                  w_completing = 1'b1;
                  w_state_next = S_PUBLISH;
               end
            end
         end
         S_PUBLISH: begin
            w_publish    = 1'b1;
            w_mask_next  = 4'b0000;
            w_state_next = S_WAIT_SYNC;
            if (w_sample && (w_k == 2'd0)) begin
               w_shadow_we  = 1'b1;
               w_mask_next  = 4'b0001;
               w_state_next = S_COLLECT;
            end
         end
         default: begin
            w_mask_next  = 4'b0000;
            w_state_next = S_WAIT_SYNC;
         end
      endcase
      // A completing or publishing frame beats a timeout in the same cycle
      w_abort = w_to_hit && !w_publish && !w_completing;
      if (w_abort) begin
         w_shadow_we  = 1'b0;
         w_mask_next  = 4'b0000;
         w_state_next = S_WAIT_SYNC;
      end
   end

   // Frame FSM state and collected-digit mask
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_WAIT_SYNC;
         r_mask  <= 4'b0000;
      end else begin
         r_state <= w_state_next;
         r_mask  <= w_mask_next;
      end
   end

   // Shadow digits of the frame being assembled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++)
            r_shadow[i] <= 4'hF;
      end else if (w_shadow_we) begin
         r_shadow[w_k] <= w_code;
      end
   end

   assign w_shadow_flat = {r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};

   // Blank and invalid digits contribute zero to the binary value
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dval
         assign w_dval[gi] = (r_shadow[gi] <= 4'd9) ? r_shadow[gi] : 4'd0;
      end
   endgenerate

   assign w_value = 14'(w_dval[3]) * 14'd1000 + 14'(w_dval[2]) * 14'd100
                  + 14'(w_dval[1]) * 14'd10   + 14'(w_dval[0]);

   // Only the four duty-cycle displays are legal frames
   always_comb begin
      w_legal     = 1'b1;
      w_legal_sel = 2'b00;
      case (w_shadow_flat)
         16'hFF25: w_legal_sel = 2'b00;
         16'hFF50: w_legal_sel = 2'b01;
         16'hFF75: w_legal_sel = 2'b10;
         16'hF100: w_legal_sel = 2'b11;
         default:  w_legal     = 1'b0;
      endcase
   end

   // Timeout counter saturates; timeout flag is set once and cleared by a frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_publish)
            r_to_cnt <= '0;
         else if (r_to_cnt != TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;

         if (w_publish)
            r_timeout <= 1'b0;
         else if (w_abort)
            r_timeout <= 1'b1;
      end
   end

   // Publish a completed frame; duty selection only moves on a legal frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_digits      <= 16'hFFFF;
         r_frame_valid <= 1'b0;
         r_value_bin   <= '0;
         r_duty        <= 2'b00;
         r_value_ok    <= 1'b0;
      end else begin
         r_frame_valid <= w_publish;
         if (w_publish) begin
            r_digits    <= w_shadow_flat;
            r_value_bin <= w_value;
            r_value_ok  <= w_legal;
            if (w_legal)
               r_duty <= w_legal_sel;
         end
      end
   end

   // Sticky flag for any sampled pattern that is not a digit or blank
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_seg_error <= 1'b0;
      else if (w_sample && (w_code == 4'hE))
         r_seg_error <= 1'b1;
   end

   assign digits_out   = r_digits;
   assign frame_valid  = r_frame_valid;
   assign value_bin    = r_value_bin;
   assign duty_sel_out = r_duty;
   assign value_ok     = r_value_ok;
   assign seg_error    = r_seg_error;
   assign timeout      = r_timeout;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture.
// Expected frames are queued as scans are driven and checked on frame_valid.
module tb_seven_seg_capture;

   localparam int SETTLE = 4;
   localparam int TMO    = 2000;
   localparam int DWELL  = 20;

   typedef struct {
      logic [15:0] dig;
      logic [13:0] val;
      logic [1:0]  duty;
      logic        ok;
      logic        serr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] digits_out;
   logic        frame_valid;
   logic [13:0] value_bin;
   logic [1:0]  duty_sel_out;
   logic        value_ok;
   logic        seg_error;
   logic        timeout;

   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   int   fv_count = 0;
   int   fv_last = 0;
   int   fv_prev = 0;
   exp_t exp_q[$];

   seven_seg_capture_if bus ();

   seven_seg_capture #(
      .CLK_FREQ       (100_000_000),
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus.slave),
      .digits_out   (digits_out),
      .frame_valid  (frame_valid),
      .value_bin    (value_bin),
      .duty_sel_out (duty_sel_out),
      .value_ok     (value_ok),
      .seg_error    (seg_error),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      cmp_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] c);
      logic [6:0] s;
      case (c)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'hF:    s = 7'b1111111;
         default: s = 7'b0101010;
      endcase
      return s;
   endfunction

   task automatic drive_digit(input int k, input logic [6:0] seg, input int n);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << k;
      bus.anodes_in   = ~one_hot;
      bus.segments_in = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan_frame(input logic [3:0] c3, input logic [3:0] c2,
                             input logic [3:0] c1, input logic [3:0] c0);
      drive_digit(0, seg_of(c0), DWELL);
      drive_digit(1, seg_of(c1), DWELL);
      drive_digit(2, seg_of(c2), DWELL);
      drive_digit(3, seg_of(c3), DWELL);
   endtask

   task automatic push_exp(input logic [15:0] dig, input logic [13:0] val,
                           input logic [1:0] duty, input logic ok, input logic serr);
      exp_t e;
      e.dig = dig; e.val = val; e.duty = duty; e.ok = ok; e.serr = serr;
      exp_q.push_back(e);
   endtask

   // Scoreboard consumer: one line per received frame
   always @(negedge clk) begin
      if (frame_valid) begin
         exp_t e;
         fv_count++;
         fv_prev = fv_last;
         fv_last = cyc;
         chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("frame @%0d: digits=%h value=%0d duty=%b ok=%b seg_err=%b timeout=%b",
                     cyc, digits_out, value_bin, duty_sel_out, value_ok, seg_error, timeout);
            chk("digits_out",   32'(digits_out),   32'(e.dig));
            chk("value_bin",    32'(value_bin),    32'(e.val));
            chk("duty_sel_out", 32'(duty_sel_out), 32'(e.duty));
            chk("value_ok",     32'(value_ok),     32'(e.ok));
            chk("seg_error",    32'(seg_error),    32'(e.serr));
            chk("timeout_clr",  32'(timeout),      32'd0);
         end
      end
   end

   initial begin
      int saved;
      bus.anodes_in   = 4'b1111;
      bus.segments_in = 7'b1111111;
      reset_n = 1'b0;
      repeat (5) @(negedge clk);

      // Reset state
      chk("rst_digits",  32'(digits_out),   32'hFFFF);
      chk("rst_fv",      32'(frame_valid),  32'd0);
      chk("rst_value",   32'(value_bin),    32'd0);
      chk("rst_duty",    32'(duty_sel_out), 32'd0);
      chk("rst_ok",      32'(value_ok),     32'd0);
      chk("rst_segerr",  32'(seg_error),    32'd0);
      chk("rst_timeout", 32'(timeout),      32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Two back-to-back "50" scans: one frame per 80 cycles
      push_exp(16'hFF50, 14'd50, 2'b01, 1'b1, 1'b0);
      scan_frame(4'hF, 4'hF, 4'd5, 4'd0);
      push_exp(16'hFF50, 14'd50, 2'b01, 1'b1, 1'b0);
      scan_frame(4'hF, 4'hF, 4'd5, 4'd0);
      chk("frames_50", 32'(exp_q.size()), 32'd0);
      chk("frame_count_2", 32'(fv_count), 32'd2);
      chk("frame_period", 32'(fv_last - fv_prev), 32'(4 * DWELL));

      // "100" then "25"
      push_exp(16'hF100, 14'd100, 2'b11, 1'b1, 1'b0);
      scan_frame(4'hF, 4'd1, 4'd0, 4'd0);
      push_exp(16'hFF25, 14'd25, 2'b00, 1'b1, 1'b0);
      scan_frame(4'hF, 4'hF, 4'd2, 4'd5);
      chk("frames_100_25", 32'(exp_q.size()), 32'd0);

      // Glitch on digit1: briefly shows 7, settles to 2
      push_exp(16'hFF25, 14'd25, 2'b00, 1'b1, 1'b0);
      drive_digit(0, seg_of(4'd5), DWELL);
      drive_digit(1, 7'b1111000, 2);
      drive_digit(1, 7'b0100100, DWELL - 2);
      drive_digit(2, seg_of(4'hF), DWELL);
      drive_digit(3, seg_of(4'hF), DWELL);
      chk("frame_glitch", 32'(exp_q.size()), 32'd0);
      chk("glitch_no_segerr", 32'(seg_error), 32'd0);

      // Move duty to 01, then a "75" whose rightmost digit is corrupted
      push_exp(16'hFF50, 14'd50, 2'b01, 1'b1, 1'b0);
      scan_frame(4'hF, 4'hF, 4'd5, 4'd0);
      push_exp(16'hFF7E, 14'd70, 2'b01, 1'b0, 1'b1);
      drive_digit(0, 7'b0101010, DWELL);
      drive_digit(1, seg_of(4'd7), DWELL);
      drive_digit(2, seg_of(4'hF), DWELL);
      drive_digit(3, seg_of(4'hF), DWELL);
      chk("frame_invalid", 32'(exp_q.size()), 32'd0);

      // Good frame afterwards: seg_error remains set
      push_exp(16'hFF50, 14'd50, 2'b01, 1'b1, 1'b1);
      scan_frame(4'hF, 4'hF, 4'd5, 4'd0);
      chk("frame_after_err", 32'(exp_q.size()), 32'd0);

      // Idle anodes long enough to time out; outputs hold
      bus.anodes_in   = 4'b1111;
      bus.segments_in = 7'b1111111;
      repeat (TMO + 100) @(negedge clk);
      chk("timeout_set",   32'(timeout),    32'd1);
      chk("timeout_dig",   32'(digits_out), 32'hFF50);
      chk("timeout_value", 32'(value_bin),  32'd50);
      chk("timeout_ok",    32'(value_ok),   32'd1);

      // Resume scanning: frame clears timeout
      push_exp(16'hFF50, 14'd50, 2'b01, 1'b1, 1'b1);
      scan_frame(4'hF, 4'hF, 4'd5, 4'd0);
      chk("frame_resume", 32'(exp_q.size()), 32'd0);
      chk("timeout_cleared", 32'(timeout), 32'd0);

      // Scan starting at digit2 produces nothing until d0 is seen
      saved = fv_count;
      drive_digit(2, seg_of(4'hF), DWELL);
      drive_digit(3, seg_of(4'hF), DWELL);
      drive_digit(0, seg_of(4'd5), DWELL);
      drive_digit(1, seg_of(4'd2), DWELL);
      chk("no_partial_frame", 32'(fv_count), 32'(saved));

      // Reset while two digits are collected
      reset_n = 1'b0;
      #1;
      chk("mid_rst_digits",  32'(digits_out),   32'hFFFF);
      chk("mid_rst_fv",      32'(frame_valid),  32'd0);
      chk("mid_rst_value",   32'(value_bin),    32'd0);
      chk("mid_rst_duty",    32'(duty_sel_out), 32'd0);
      chk("mid_rst_ok",      32'(value_ok),     32'd0);
      chk("mid_rst_segerr",  32'(seg_error),    32'd0);
      chk("mid_rst_timeout", 32'(timeout),      32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Remaining digits of the interrupted frame must not complete anything
      drive_digit(2, seg_of(4'hF), DWELL);
      drive_digit(3, seg_of(4'hF), DWELL);
      chk("no_frame_after_rst", 32'(fv_count), 32'(saved));

      // First full d0..d3 sequence after reset yields a frame
      push_exp(16'hFF25, 14'd25, 2'b00, 1'b1, 1'b0);
      scan_frame(4'hF, 4'hF, 4'd2, 4'd5);
      chk("frame_after_rst", 32'(exp_q.size()), 32'd0);
      chk("frame_count_after_rst", 32'(fv_count), 32'(saved + 1));

      bus.anodes_in = 4'b1111;
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
